// File: rtl/bmu_pkg.sv
// Shared definitions for the bit-manipulation units: option codes, sequencer states, XLEN.
package bmu_pkg;

   localparam int XLEN = 32;

   localparam logic [4:0] OPT_CLMUL  = 5'b00001;
   localparam logic [4:0] OPT_CLMULH = 5'b00010;
   localparam logic [4:0] OPT_CLMULR = 5'b00011;
   localparam logic [4:0] OPT_CLZ    = 5'b00100;
   localparam logic [4:0] OPT_CPOP   = 5'b00101;
   localparam logic [4:0] OPT_CTZ    = 5'b00110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   function automatic logic is_clmul(input logic [4:0] opt);
      return (opt == OPT_CLMUL) || (opt == OPT_CLMULH) || (opt == OPT_CLMULR);
   endfunction

   function automatic logic is_supported(input logic [4:0] opt);
      return is_clmul(opt) || (opt == OPT_CLZ) || (opt == OPT_CPOP) || (opt == OPT_CTZ);
   endfunction

endpackage

// File: rtl/bmu_bitcount_step.sv
// One scan slice of CLZ/CTZ/CPOP: returns this slice's contribution and the sticky found flag.
module bmu_bitcount_step
   import bmu_pkg::*;
#(
   parameter int W  = 4,
   parameter int CW = $clog2(W) + 1
) (
   input  logic [W-1:0]  slice,
   input  logic [4:0]    mode,
   input  logic          found_in,
   output logic [CW-1:0] inc,
   output logic          found_out
);

   logic [W-1:0]  slice_rev;
   logic [W-1:0]  src;
   logic [CW-1:0] lz_cnt;
   logic [CW-1:0] pop_cnt;
   logic          seen;

   // CTZ reuses the leading-zero scan on the bit-reversed slice.
   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_rev
         assign slice_rev[gi] = slice[W-1-gi];
      end
   endgenerate

   always_comb begin
      src     = (mode == OPT_CTZ) ? slice_rev : slice;
      lz_cnt  = '0;
      pop_cnt = '0;
      seen    = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         pop_cnt = pop_cnt + CW'(src[i]);
         if (!seen) begin
            if (src[i]) seen = 1'b1;
            else        lz_cnt = lz_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      inc = '0;
      if (mode == OPT_CPOP)  inc = pop_cnt;
      else if (!found_in)    inc = lz_cnt;
      found_out = found_in | (|slice);
   end

endmodule

// File: rtl/bmu_seq_unit.sv
// Iterative CLMUL/CLMULH/CLMULR/CLZ/CTZ/CPOP unit with fixed, data-independent latency.
module bmu_seq_unit
   import bmu_pkg::*;
#(
   parameter int CLMUL_BITS_PER_CYCLE = 1,
   parameter int COUNT_BITS_PER_CYCLE = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [4:0]      option,
   input  logic [XLEN-1:0] in_x,
   input  logic [XLEN-1:0] in_y,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CB = CLMUL_BITS_PER_CYCLE;
   localparam int KB = COUNT_BITS_PER_CYCLE;
   localparam int CW = $clog2(KB) + 1;
   localparam logic [5:0] CLMUL_LAST = 6'(XLEN / CB - 1);
   localparam logic [5:0] COUNT_LAST = 6'(XLEN / KB - 1);

   seq_state_e        state_reg, state_next;
   logic [4:0]        opt_reg;
   logic [2*XLEN-1:0] mcand_reg;
   logic [2*XLEN-1:0] acc_reg, acc_next;
   logic [XLEN-1:0]   mplier_reg;
   logic [XLEN-1:0]   scan_reg;
   logic [XLEN-1:0]   result_reg, result_next;
   logic [5:0]        step_reg;
   logic [5:0]        bcnt_reg, bcnt_next;
   logic              found_reg, found_next;
   logic              accept, accept_run, last_step;
   logic [KB-1:0]     slice;
   logic [CW-1:0]     slice_inc;
   logic [2*XLEN-1:0] partial [CB];

   assign accept     = start && !flush && (state_reg != ST_RUN);
   assign accept_run = accept && is_supported(option);
   assign last_step  = (state_reg == ST_RUN) &&
                       (step_reg == (is_clmul(opt_reg) ? CLMUL_LAST : COUNT_LAST));

   // Each consumed multiplier bit contributes a shifted copy of the multiplicand.
   generate
      for (genvar gi = 0; gi < CB; gi++) begin : g_part
         assign partial[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
      end
   endgenerate

   always_comb begin
      acc_next = acc_reg;
      for (int k = 0; k < CB; k++) acc_next = acc_next ^ partial[k];
   end

   // CTZ scans upward from the LSB; CLZ and CPOP scan downward from the MSB.
   assign slice = (opt_reg == OPT_CTZ) ? scan_reg[KB-1:0] : scan_reg[XLEN-1 -: KB];

   bmu_bitcount_step #(.W(KB), .CW(CW)) u_step (
      .slice     (slice),
      .mode      (opt_reg),
      .found_in  (found_reg),
      .inc       (slice_inc),
      .found_out (found_next)
   );

   assign bcnt_next = bcnt_reg + 6'(slice_inc);

   always_comb begin
      unique case (opt_reg)
         OPT_CLMUL:  result_next = acc_next[XLEN-1:0];
         OPT_CLMULH: result_next = acc_next[2*XLEN-1:XLEN];
         OPT_CLMULR: result_next = acc_next[2*XLEN-2:XLEN-1];
         default:    result_next = {{(XLEN-6){1'b0}}, bcnt_next};
      endcase
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (flush)      state_next = ST_IDLE;
            else if (start) state_next = is_supported(option) ? ST_RUN : ST_DONE;
            else            state_next = ST_IDLE;
         end
         ST_RUN: begin
            if (flush)          state_next = ST_IDLE;
            else if (last_step) state_next = ST_DONE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opt_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         scan_reg   <= '0;
         acc_reg    <= '0;
         step_reg   <= '0;
         bcnt_reg   <= '0;
         found_reg  <= 1'b0;
         result_reg <= '0;
      end else if (accept_run) begin
         opt_reg    <= option;
         mcand_reg  <= {{XLEN{1'b0}}, in_x};
         mplier_reg <= in_y;
         scan_reg   <= in_x;
         acc_reg    <= '0;
         step_reg   <= '0;
         bcnt_reg   <= '0;
         found_reg  <= 1'b0;
      end else if (accept) begin
         result_reg <= in_x;
      end else if (state_reg == ST_RUN && !flush) begin
         mcand_reg  <= mcand_reg << CB;
         mplier_reg <= mplier_reg >> CB;
         acc_reg    <= acc_next;
         if (opt_reg == OPT_CTZ) scan_reg <= scan_reg >> KB;
         else                    scan_reg <= scan_reg << KB;
         bcnt_reg   <= bcnt_next;
         found_reg  <= found_next;
         step_reg   <= step_reg + 6'd1;
         if (last_step) result_reg <= result_next;
      end
   end

   assign busy   = (state_reg == ST_RUN);
   assign done   = (state_reg == ST_DONE);
   assign result = result_reg;

endmodule
